// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHECK state).
package loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int LEN_W      = 16;
  localparam int LANES      = 4;
  localparam int LANE_IDX_W = 2;

  // Loader FSM states; CHECK only exists when the checksum trailer is enabled.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_BYTE   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
`ifdef LOADER_CHECKSUM_EN
    S_ERR    = 3'd6,
    S_CHECK  = 3'd7
`else
    S_ERR    = 3'd6
`endif
  } state_e;

  // Byte address of word 'count' relative to 'base'; wraps modulo 2^32.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                  input logic [LEN_W-1:0]  count);
    return base + {14'b0, count, 2'b00};
  endfunction

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
// word_o already contains the byte being accepted, so the caller can latch the
// complete word on the same edge that word_full_o is reported.
module word_packer
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [LANE_IDX_W-1:0] lane_q;
  logic [WORD_W-1:0]     word_q;
  logic [WORD_W-1:0]     word_d;

  // Insert the incoming byte into its lane of the partially built word.
  always_comb begin
    word_d = word_q;
    word_d[{lane_q, 3'b000} +: BYTE_W] = byte_i;
  end

  assign word_o      = word_d;
  assign word_full_o = byte_vld_i && (lane_q == LANE_IDX_W'(LANES - 1));

  // Lane counter and word register; the counter wraps to lane 0 after lane 3.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (byte_vld_i) begin
      lane_q <= lane_q + 1'b1;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a length-prefixed byte stream, packs it into
// 32-bit words and writes them to instruction memory, holding the core in
// reset until a complete image is loaded.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [BYTE_W-1:0] RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic [WORD_W-1:0] MemAddr,
  output logic [WORD_W-1:0] MemData,
  output logic              MemWr,
  output logic              CpuReset,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [LEN_W-1:0]  WordCount
);

  state_e              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    word_count_q;
  logic [WORD_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_data_q;
  logic                mem_wr_q;
  logic                cpu_reset_q;
  logic                done_q;
  logic                error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   xor_q;
`endif

  logic                xfer;
  logic                packer_start;
  logic                packer_vld;
  logic                word_full;
  logic [WORD_W-1:0]   packed_word;
  logic [LEN_W-1:0]    len_w;
  logic [LEN_W-1:0]    cnt_inc;

  // Stream-side readiness and busy flag are pure functions of the state.
  always_comb begin
    RxReady = 1'b0;
    Busy    = 1'b1;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_BYTE: RxReady = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:                    RxReady = 1'b1;
`endif
      S_IDLE, S_DONE, S_ERR:      Busy    = 1'b0;
      default:                    RxReady = 1'b0;
    endcase
  end

  assign xfer         = RxValid && RxReady;
  assign packer_start = Start && !Busy;
  assign packer_vld   = xfer && (state_q == S_BYTE);
  assign len_w        = {RxData, len_q[BYTE_W-1:0]};
  assign cnt_inc      = word_count_q + 1'b1;

  word_packer u_packer (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .start_i     (packer_start),
    .byte_vld_i  (packer_vld),
    .byte_i      (RxData),
    .word_o      (packed_word),
    .word_full_o (word_full)
  );

  // Loader FSM with registered memory-write and status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_count_q <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wr_q     <= 1'b0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      mem_wr_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (Start) begin
            state_q      <= S_LEN_LO;
            word_count_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q[BYTE_W-1:0] <= RxData;
            state_q           <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_q[LEN_W-1:BYTE_W] <= RxData;
            if (32'(len_w) > MAX_WORDS) begin
              state_q     <= S_ERR;
              error_q     <= 1'b1;
              cpu_reset_q <= 1'b1;
            end else if (len_w == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q     <= S_CHECK;
`else
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
`endif
            end else begin
              state_q <= S_BYTE;
            end
          end
        end
        S_BYTE: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ RxData;
`endif
            if (word_full) begin
              mem_wr_q   <= 1'b1;
              mem_addr_q <= word_addr(BASE_ADDR, word_count_q);
              mem_data_q <= packed_word;
              state_q    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          word_count_q <= cnt_inc;
          if (cnt_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_q     <= S_CHECK;
`else
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
`endif
          end else begin
            state_q <= S_BYTE;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            if (RxData == xor_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q     <= S_ERR;
              error_q     <= 1'b1;
              cpu_reset_q <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign MemAddr   = mem_addr_q;
  assign MemData   = mem_data_q;
  assign MemWr     = mem_wr_q;
  assign CpuReset  = cpu_reset_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign WordCount = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Honours LOADER_CHECKSUM_EN to exercise the trailing checksum byte.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 1024;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        Clk, Reset, Start, RxValid, RxReady, MemWr, CpuReset, Busy, Done, Error;
  logic [7:0]  RxData;
  logic [31:0] MemAddr, MemData;
  logic [15:0] WordCount;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
    .RxReady(RxReady), .MemAddr(MemAddr), .MemData(MemData), .MemWr(MemWr),
    .CpuReset(CpuReset), .Busy(Busy), .Done(Done), .Error(Error), .WordCount(WordCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         sb[$];
  logic [31:0] img[$];
  int n_assert = 0;
  int n_fail   = 0;
  int wr_seen  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every MemWr cycle must match the next scoreboard entry.
  initial begin
    wr_t e;
    forever begin
      @(negedge Clk);
      if (MemWr === 1'b1) begin
        wr_seen++;
        n_assert++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_memwr: observed addr 0x%0h data 0x%0h expected no write",
                 MemAddr, MemData);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("memaddr", MemAddr, e.a);
          chk("memdata", MemData, e.d);
        end
      end
    end
  end

  task automatic pulse_start();
    RxValid = 1'b0;
    Start   = 1'b1;
    @(posedge Clk); #1;
    Start   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int t;
    t = 0;
    if (stall) begin
      RxValid = 1'b0;
      @(posedge Clk); #1;
    end
    RxValid = 1'b1;
    RxData  = b;
    while (RxReady !== 1'b1 && t < 50) begin
      @(posedge Clk); #1;
      t++;
    end
    chk("rxready_wait", 32'(t < 50), 32'd1);
    @(posedge Clk); #1;
    RxValid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (Busy !== 1'b0 && t < 200) begin
      @(posedge Clk); #1;
      t++;
    end
    chk("idle_wait", 32'(t < 200), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rxready"},  32'(RxReady),   32'd0);
    chk({tag, "_memaddr"},  MemAddr,        32'd0);
    chk({tag, "_memdata"},  MemData,        32'd0);
    chk({tag, "_memwr"},    32'(MemWr),     32'd0);
    chk({tag, "_cpureset"}, 32'(CpuReset),  32'd1);
    chk({tag, "_busy"},     32'(Busy),      32'd0);
    chk({tag, "_done"},     32'(Done),      32'd0);
    chk({tag, "_error"},    32'(Error),     32'd0);
    chk({tag, "_wcount"},   32'(WordCount), 32'd0);
  endtask

  // Full load of the words in img[0..n-1]; the checksum trailer is the XOR
  // of all data bytes, or a corrupted copy of it when bad_sum is set.
  task automatic load_image(input int n, input bit stall, input bit bad_sum, input string tag);
    logic [7:0]  x, b;
    logic [15:0] nl;
    int c0, wr0;
    bit fail_exp;
    x = 8'h00;
    nl = 16'(n);
    wr0 = wr_seen;
    fail_exp = (CK == 1) && bad_sum;
    for (int i = 0; i < n; i++) sb.push_back('{a: BASE + 32'(4 * i), d: img[i]});
    pulse_start();
    c0 = cyc;
    send_byte(nl[7:0], stall);
    send_byte(nl[15:8], stall);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        x = x ^ b;
        send_byte(b, stall);
      end
    end
    if (CK == 1) send_byte(bad_sum ? (x ^ 8'h11) : x, stall);
    wait_idle();
    if (!stall) chk({tag, "_cycles"}, 32'(cyc - c0), 32'(2 + 5 * n + CK));
    chk({tag, "_done"},     32'(Done),          32'(!fail_exp));
    chk({tag, "_error"},    32'(Error),         32'(fail_exp));
    chk({tag, "_cpureset"}, 32'(CpuReset),      32'(fail_exp));
    chk({tag, "_wcount"},   32'(WordCount),     32'(n));
    chk({tag, "_writes"},   32'(wr_seen - wr0), 32'(n));
    chk({tag, "_sb_empty"}, 32'(sb.size()),     32'd0);
  endtask

  initial begin
    int wr0;
    Reset = 1'b1; Start = 1'b0; RxValid = 1'b0; RxData = 8'h00;
    repeat (3) @(posedge Clk);
    // Start in the same cycle as Reset must be ignored.
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check_reset_vals("reset");
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("idle_busy", 32'(Busy), 32'd0);

    // Two-word image, back-to-back bytes.
    img = '{32'h0000_0013, 32'h0010_0093};
    load_image(2, 1'b0, 1'b0, "img2");

    // Same image with RxValid dropped before every byte.
    load_image(2, 1'b1, 1'b0, "img2_stall");

    // Zero-length image.
    img = '{};
    load_image(0, 1'b0, 1'b0, "len0");

    // Over-long image: MAX_WORDS+1 = 0x0401.
    wr0 = wr_seen;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    wait_idle();
    chk("toolong_error",    32'(Error),         32'd1);
    chk("toolong_done",     32'(Done),          32'd0);
    chk("toolong_cpureset", 32'(CpuReset),      32'd1);
    chk("toolong_writes",   32'(wr_seen - wr0), 32'd0);

    // Recovery with a fresh valid image.
    img = '{32'h0000_0013, 32'h0010_0093};
    load_image(2, 1'b0, 1'b0, "reload");

    // Reset after the 6th byte (and its WRITE) of a 2-word load.
    wr0 = wr_seen;
    sb.push_back('{a: BASE, d: 32'h0000_0013});
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check_reset_vals("midreset");
    @(posedge Clk); #1;
    Reset = 1'b0;
    RxValid = 1'b1; RxData = 8'h93;
    repeat (8) @(posedge Clk);
    #1;
    RxValid = 1'b0;
    chk("midreset_writes",   32'(wr_seen - wr0), 32'd1);
    chk("midreset_sb_empty", 32'(sb.size()),     32'd0);
    chk("midreset_busy",     32'(Busy),          32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Image 11 22 33 44: XOR of the data bytes is 0x44; 0x55 is a mismatch.
    img = '{32'h4433_2211};
    load_image(1, 1'b0, 1'b0, "ck_ok");
    load_image(1, 1'b0, 1'b1, "ck_bad");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
